// File: rtl/clint_timer_pkg.sv
// Purpose: shared CLINT constants, window configuration and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clint_timer_pkg;

    localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP_ADDR  = 32'h0200_C000;
    localparam int          CLK_DIVIDER_RTC = 4;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP    = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = CLINT_MTIMECMP + 16'h0004;
    localparam logic [15:0] CLINT_MTIME       = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = CLINT_MTIME + 16'h0004;

    typedef enum logic {IDLE, RESP} clint_state_t;

    // Byte-lane merge of a store into an existing 32-bit register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// Purpose: divides the core clock into a single-cycle RTC tick.
// Latency: tick high for one cycle every 2*(div+1) clocks, first at clock 2*(div+1) after reset.
// Backpressure: none; free-running.
module clint_rtc_tick
    import clint_timer_pkg::*;
#(
    parameter int clk_divider_rtc = CLK_DIVIDER_RTC
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int              PERIOD  = 2 * (clk_divider_rtc + 1);
    localparam int              CW      = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/clint_timer.sv
// Purpose: core-local interruptor: msip, 64-bit mtimecmp and RTC-driven mtime on a valid/ready data port.
// Latency: mem_ready pulses one cycle after the accepting edge; mtip lags register changes by one cycle.
// Backpressure: one request in flight; mem_valid held during the response cycle is not re-accepted.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [31:0] clint_base_addr = CLINT_BASE_ADDR,
    parameter int          clk_divider_rtc = CLK_DIVIDER_RTC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mtip,
    output logic        msip
);

    localparam logic [31:0] WIN_SIZE = CLINT_TOP_ADDR - CLINT_BASE_ADDR;

    clint_state_t state;
    logic [63:0]  mtime;
    logic [63:0]  mtimecmp;
    logic         tick;

    clint_rtc_tick #(.clk_divider_rtc(clk_divider_rtc)) u_rtc_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    logic [31:0] off;
    logic [15:0] word;
    logic        accept, data_acc, wr;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;

    // Addresses below the base wrap to huge offsets and fall outside the window.
    assign off        = mem_addr - clint_base_addr;
    assign word       = {off[15:2], 2'b00};
    assign accept     = (state == IDLE) && mem_valid;
    assign data_acc   = accept && !mem_instr && (off < WIN_SIZE);
    assign wr         = data_acc && (mem_wstrb != 4'h0);
    assign sel_msip   = (word == CLINT_MSIP);
    assign sel_cmp_lo = (word == CLINT_MTIMECMP);
    assign sel_cmp_hi = (word == CLINT_MTIMECMP_HI);
    assign sel_mt_lo  = (word == CLINT_MTIME);
    assign sel_mt_hi  = (word == CLINT_MTIME_HI);

    logic [31:0] rd_val;
    always_comb begin
        rd_val = 32'h0;
        if (data_acc) begin
            if (sel_msip)   rd_val = {31'h0, msip};
            if (sel_cmp_lo) rd_val = mtimecmp[31:0];
            if (sel_cmp_hi) rd_val = mtimecmp[63:32];
            if (sel_mt_lo)  rd_val = mtime[31:0];
            if (sel_mt_hi)  rd_val = mtime[63:32];
        end
    end

    // A store to an mtime half overrides the tick for that half; a stored lo
    // half also suppresses the carry into hi.
    logic [63:0] mtime_inc;
    logic [31:0] mt_lo_nxt, mt_hi_nxt;
    assign mtime_inc = mtime + 64'd1;

    always_comb begin
        mt_lo_nxt = tick ? mtime_inc[31:0]  : mtime[31:0];
        mt_hi_nxt = tick ? mtime_inc[63:32] : mtime[63:32];
        if (wr && sel_mt_lo) begin
            mt_lo_nxt = merge_bytes(mtime[31:0], mem_wdata, mem_wstrb);
            mt_hi_nxt = mtime[63:32];
        end
        if (wr && sel_mt_hi) begin
            mt_hi_nxt = merge_bytes(mtime[63:32], mem_wdata, mem_wstrb);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            mtip      <= 1'b0;
        end else begin
            mtime <= {mt_hi_nxt, mt_lo_nxt};
            mtip  <= (mtime >= mtimecmp);
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= rd_val;
                        if (wr && sel_msip && mem_wstrb[0]) msip <= mem_wdata[0];
                        if (wr && sel_cmp_lo)
                            mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], mem_wdata, mem_wstrb);
                        if (wr && sel_cmp_hi)
                            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], mem_wdata, mem_wstrb);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Randomized and directed bench for clint_timer against a cycle-counting reference model.
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_ready, mtip, msip;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    clint_timer dut (
        .clock     (clock),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mtip      (mtip),
        .msip      (msip)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: time is counted in clock edges since reset release;
    // every tenth edge advances mtime.
    int unsigned m_cyc;
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_rdata;
    bit          m_msip, m_mtip, m_busy, m_ready;

    function automatic logic [31:0] put_bytes(input logic [31:0] v, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] offs);
        case (offs)
            32'h0000: return {31'h0, m_msip};
            32'h4000: return m_cmp[31:0];
            32'h4004: return m_cmp[63:32];
            32'hBFF8: return m_mtime[31:0];
            32'hBFFC: return m_mtime[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_mtime = 64'h0; m_cmp = '1;
            m_msip = 1'b0; m_mtip = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_rdata = 32'h0;
        end else begin
            bit          tick, acc, wr;
            logic [31:0] offs;
            logic [63:0] t;
            tick   = (m_cyc % 10) == 9;
            m_cyc  = m_cyc + 1;
            acc    = mem_valid && !m_busy;
            offs   = (mem_addr - BASE) & 32'hFFFF_FFFC;
            wr     = acc && !mem_instr && (offs < 32'hC000) && (mem_wstrb != 4'h0);
            m_mtip = (m_mtime >= m_cmp);
            if (acc) m_rdata = (mem_instr || offs >= 32'hC000) ? 32'h0 : model_read(offs);
            m_ready = acc;
            m_busy  = acc;
            t = m_mtime + (tick ? 64'd1 : 64'd0);
            if (wr && offs == 32'hBFF8) t = {m_mtime[63:32], put_bytes(m_mtime[31:0], mem_wdata, mem_wstrb)};
            if (wr && offs == 32'hBFFC) t[63:32] = put_bytes(m_mtime[63:32], mem_wdata, mem_wstrb);
            if (wr && offs == 32'h4000) m_cmp[31:0]  = put_bytes(m_cmp[31:0], mem_wdata, mem_wstrb);
            if (wr && offs == 32'h4004) m_cmp[63:32] = put_bytes(m_cmp[63:32], mem_wdata, mem_wstrb);
            if (wr && offs == 32'h0000 && mem_wstrb[0]) m_msip = mem_wdata[0];
            m_mtime = t;
        end
    end

    always @(negedge clock) begin
        if (reset && chk_en) begin
            chk("mtip", 64'(mtip), 64'(m_mtip));
            chk("msip", 64'(msip), 64'(m_msip));
            chk("mem_ready", 64'(mem_ready), 64'(m_ready));
        end
    end

    // Called just after a falling edge; returns just after the falling edge following the response.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input bit instr, output logic [31:0] rdata);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
        @(posedge clock);
        @(negedge clock);
        chk("ready_pulse", 64'(mem_ready), 64'd1);
        chk($sformatf("rdata@%08h", addr), 64'(mem_rdata), 64'(m_rdata));
        rdata = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'h0; mem_instr = 1'b0;
        @(negedge clock);
        chk("ready_drop", 64'(mem_ready), 64'd0);
    endtask

    task automatic wait_phase(input int unsigned p);
        int n;
        n = 0;
        while ((m_cyc % 10) != p && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("phase_wait", 64'((m_cyc % 10) == p), 64'd1);
    endtask

    logic [31:0] r;
    logic [31:0] offs_tbl [8] = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8,
                                  32'hBFFC, 32'h0100, 32'h8000, 32'h0000};

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk_en = 1'b1;
        chk("rst_mtip", 64'(mtip), 64'd0);
        chk("rst_msip", 64'(msip), 64'd0);
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);

        repeat (100) @(negedge clock);
        xfer(BASE + 32'hBFF8, 32'h0, 4'h0, 1'b0, r);
        chk("idle100_mtime_lo", 64'(r), 64'd10);

        xfer(BASE, 32'h1, 4'h1, 1'b0, r);
        chk("msip_set", 64'(msip), 64'd1);
        xfer(BASE, 32'h0, 4'h0, 1'b0, r);
        chk("msip_read", 64'(r), 64'd1);
        xfer(BASE, 32'h0, 4'h1, 1'b0, r);
        chk("msip_clr", 64'(msip), 64'd0);
        xfer(BASE, 32'h1, 4'h2, 1'b0, r);
        chk("msip_strb_ignored", 64'(msip), 64'd0);

        xfer(BASE + 32'h4004, 32'h0, 4'hF, 1'b0, r);
        xfer(BASE + 32'h4000, 32'd20, 4'hF, 1'b0, r);
        for (int i = 0; i < 400 && !mtip; i++) @(negedge clock);
        chk("mtip_rise", 64'(mtip), 64'd1);
        xfer(BASE + 32'hBFF8, 32'h0, 4'h0, 1'b0, r);
        chk("mtip_rise_mtime", 64'(r), 64'd20);
        xfer(BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        chk("mtip_clear", 64'(mtip), 64'd0);

        xfer(BASE + 32'hBFFC, 32'h0, 4'hF, 1'b0, r);
        wait_phase(0);
        xfer(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        repeat (8) @(negedge clock);
        xfer(BASE + 32'hBFF8, 32'h0, 4'h0, 1'b0, r);
        chk("carry_lo", 64'(r), 64'd0);
        xfer(BASE + 32'hBFFC, 32'h0, 4'h0, 1'b0, r);
        chk("carry_hi", 64'(r), 64'd1);

        wait_phase(9);
        xfer(BASE + 32'hBFF8, 32'h55, 4'hF, 1'b0, r);
        xfer(BASE + 32'hBFF8, 32'h0, 4'h0, 1'b0, r);
        chk("tick_lost_lo", 64'(r), 64'h55);

        xfer(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        wait_phase(0);
        xfer(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        repeat (8) @(negedge clock);
        xfer(BASE + 32'hBFFC, 32'h0, 4'h0, 1'b0, r);
        chk("wrap_hi", 64'(r), 64'd0);

        xfer(BASE + 32'h0100, 32'hDEAD_BEEF, 4'hF, 1'b0, r);
        xfer(BASE + 32'h0100, 32'h0, 4'h0, 1'b0, r);
        chk("unmapped_read", 64'(r), 64'd0);
        xfer(BASE + 32'h4000, 32'h0, 4'h0, 1'b1, r);
        chk("instr_read", 64'(r), 64'd0);
        xfer(BASE, 32'h1, 4'hF, 1'b1, r);
        chk("instr_no_write", 64'(msip), 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            bit          ins;
            a   = offs_tbl[$urandom_range(7)];
            if ($urandom_range(7) == 0) a = $urandom_range(32'hBFFF);
            a   = BASE + a + 32'($urandom_range(3));
            d   = $urandom;
            if ($urandom_range(1) == 1 && a[15:12] == 4'h4) d = $urandom_range(400);
            s   = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
            ins = ($urandom_range(7) == 0);
            xfer(a, d, s, ins, r);
            repeat ($urandom_range(3)) @(negedge clock);
        end

        xfer(BASE + 32'h4000, 32'h1234, 4'hF, 1'b0, r);
        mem_valid = 1'b1; mem_addr = BASE + 32'h4000; mem_wstrb = 4'h0;
        @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("ready_abort", 64'(mem_ready), 64'd0);
        mem_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        xfer(BASE + 32'h4000, 32'h0, 4'h0, 1'b0, r);
        chk("rst_cmp_lo", 64'(r), 64'hFFFF_FFFF);
        xfer(BASE + 32'h4004, 32'h0, 4'h0, 1'b0, r);
        chk("rst_cmp_hi", 64'(r), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
